// File: rtl/sar_search.sv
// sar_search: successive-approximation search driving an external magnitude comparator.
// Define SAR_PROTOCOL_CHECK_EN to flag and abort on malformed gt/lt/eq responses.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] VERIFY = 2'd2;
    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] bit_cur;
    logic [WIDTH-1:0] bit_nxt;
    logic [WIDTH-1:0] acc_nx;
    logic             fault;
    assign busy    = state != IDLE;
    assign bit_cur = WIDTH'(1) << idx;
    assign bit_nxt = bit_cur >> 1;
    // Any response other than gt, eq or an explicit lt counts as lt.
    assign acc_nx  = gt ? (acc | bit_cur) : acc;
`ifdef SAR_PROTOCOL_CHECK_EN
    assign fault = ~((gt ^ lt ^ eq) & ~(gt & lt & eq));
`else
    assign fault = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            trial  <= '0;
            result <= '0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state  <= SEARCH;
                    trial  <= WIDTH'(1) << (WIDTH - 1);
                    acc    <= '0;
                    idx    <= IW'(WIDTH - 1);
                    result <= '0;
                    found  <= 1'b0;
                    err    <= 1'b0;
                end
            end else if (fault) begin
                err    <= 1'b1;
                done   <= 1'b1;
                found  <= 1'b0;
                result <= trial;
                state  <= IDLE;
            end else if (state == SEARCH) begin
                if (eq) begin
                    result <= trial;
                    found  <= 1'b1;
                    done   <= 1'b1;
                    state  <= IDLE;
                end else begin
                    // bit_nxt is zero on the last bit, so trial settles on acc for VERIFY.
                    acc   <= acc_nx;
                    trial <= acc_nx | bit_nxt;
                    if (idx == '0)
                        state <= VERIFY;
                    else
                        idx <= idx - IW'(1);
                end
            end else if (state == VERIFY) begin
                result <= trial;
                found  <= eq;
                done   <= 1'b1;
                state  <= IDLE;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed checks of sar_search against a behavioural comparator.
module tb_sar_search;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       inj = 1'b0;
    logic [3:0] target = '0;
    logic       gt, lt, eq;
    logic [3:0] trial, result;
    logic       busy, done, found, err;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    // Injection forces the illegal gt=lt=1 response.
    assign gt = inj | (target > trial);
    assign lt = inj | (target < trial);
    assign eq = ~inj & (target == trial);

    sar_search #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .gt(gt), .lt(lt), .eq(eq),
        .trial(trial), .busy(busy), .done(done), .result(result),
        .found(found), .err(err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic search(input int tgt, input int mid, input int inj_at, input int pk_exp,
                          input int lat_exp, input int res_exp, input int found_exp,
                          input int err_exp, input string tag);
        int lat;
        int pk;
        target = 4'(tgt);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        pk = 0;
        while (!done && lat < 20) begin
            if (busy) pk = (pk << 4) | int'(trial);
            start = (mid != 0) && (lat == 2);
            inj = (lat == inj_at);
            @(posedge clk);
            #1 lat++;
        end
        start = 1'b0;
        inj = 1'b0;
        chk({tag, "_trials"}, pk, pk_exp);
        chk({tag, "_lat"}, lat, lat_exp);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_result"}, int'(result), res_exp);
        chk({tag, "_found"}, int'(found), found_exp);
        chk({tag, "_err"}, int'(err), err_exp);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_trial", int'(trial), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk) rst = 1'b0;

        search(11, 0, 0, 'h8CAB, 5, 11, 1, 0, "t11");
        search(0, 0, 0, 'h84210, 6, 0, 1, 0, "t0");
        search(15, 0, 0, 'h8CEF, 5, 15, 1, 0, "t15");
        search(8, 0, 0, 'h8, 2, 8, 1, 0, "t8");
        search(5, 1, 0, 'h8465, 5, 5, 1, 0, "t5_midstart");

        // Start in the done cycle must be accepted on the next edge.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("acc_busy", int'(busy), 1);
        chk("acc_result", int'(result), 0);
        chk("acc_found", int'(found), 0);
        chk("acc_trial", int'(trial), 8);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("acc_done_result", int'(result), 5);
        chk("acc_done_found", int'(found), 1);

        // Asynchronous reset mid-search.
        target = 4'd11;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 chk("ar_pre_trial", int'(trial), 12);
        #2 rst = 1'b1;
        #1;
        chk("ar_trial", int'(trial), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_done", int'(done), 0);
        chk("ar_found", int'(found), 0);
        chk("ar_result", int'(result), 0);
        @(negedge clk) rst = 1'b0;
        search(6, 0, 0, 'h846, 4, 6, 1, 0, "t6_after_rst");

`ifdef SAR_PROTOCOL_CHECK_EN
        search(11, 0, 2, 'h8C, 3, 12, 0, 1, "proto");
`else
        search(11, 0, 2, 'h8CEDC, 6, 12, 0, 0, "proto");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search engine that locates an unknown target value through a magnitude comparator.
- Drives a registered trial value toward a comparator and consumes its gt/lt/eq response (target vs trial), one compare per clock.
- Used wherever a value is only observable through comparison, e.g. threshold finding or a hidden-value probe. The comparator itself sits outside this block.

Parameters:
- WIDTH, 4, bit width of trial, target and result.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a search; sampled only when busy=0
- gt  input  1  comparator: target > trial
- lt  input  1  comparator: target < trial
- eq  input  1  comparator: target == trial
- trial  output  WIDTH  registered value presented to the comparator
- busy  output  1  high while a search is in progress
- done  output  1  one-cycle pulse when a search ends
- result  output  WIDTH  final value; held until the next accepted start
- found  output  1  result confirmed by an eq response; held with result
- err  output  1  protocol error flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, rst=1): the FSM goes to IDLE. trial, result, bit index and accumulator are 0. busy, done, found and err are 0.
- Responses are sampled on the clock edge that ends each cycle spent in SEARCH or VERIFY. The comparator is combinational on trial; trial is a register, so there is no combinational loop.
- IDLE, start=1:
  - next state SEARCH
  - trial = 1<<(WIDTH-1), acc = 0, idx = WIDTH-1
  - busy = 1; found, err and result cleared
- SEARCH, one edge per bit. Response decode priority is eq > gt > lt; no line asserted is treated as lt.
  - eq: result = trial, found = 1, done pulse, go to IDLE (early exit).
  - gt: acc = trial (keep bit idx).
  - lt: acc = trial with bit idx cleared.
  - If idx > 0 and not eq: idx -= 1, trial = new acc | (1<<idx).
  - If idx == 0 and not eq: trial = new acc, go to VERIFY.
- VERIFY, one edge:
  - result = trial, found = eq, done pulse, go to IDLE.
  - Needed because the trial pattern never equals target 0 during SEARCH.
- Latency from the start edge to done high:
  - k+1 cycles on an eq exit at the k-th compare
  - WIDTH+2 cycles worst case (WIDTH compares + VERIFY)
- busy is 0 in the same cycle done is high, so start is accepted in that cycle. A new search begins next edge; result and found clear on acceptance.
- start while busy=1 is ignored; no queueing.
- rst mid-search aborts immediately to the reset values.
- trial is only updated as above; it never wraps or exceeds 2^WIDTH-1.

Optional Feature:
- Macro: SAR_PROTOCOL_CHECK_EN.
- Defined:
  - In SEARCH or VERIFY, a response with zero lines asserted, or more than one of gt/lt/eq asserted, sets err = 1.
  - The search aborts that edge: go to IDLE, done pulse, found = 0, result = trial at the fault.
  - err holds until the next accepted start or rst.
- Undefined:
  - err is tied 0.
  - The priority decode above applies to every response.

Test Plan:
- Model comparator with target=11, pulse start -> trials 8,12,10,11. done 5 cycles after start edge, result=11, found=1.
- target=0 -> trials 8,4,2,1 then VERIFY trial 0. done 6 cycles after start, result=0, found=1.
- target=15 -> trials 8,12,14,15 with eq on the 4th compare; result=15, found=1. target=8 -> eq on the first trial, done 2 cycles after start, result=8.
- Start during a search (target=5) ignored; start during the done cycle accepted, and busy is high next cycle with result/found cleared.
- Assert rst while trial=12 -> trial=0, busy=0, done=0, found=0 asynchronously. The next start produces a correct search (target=6 -> result=6).
- With SAR_PROTOCOL_CHECK_EN, force gt=lt=1 on the 2nd compare -> done pulse, err=1, found=0, result=12 (target=11 model). Without the macro the same stimulus gives err=0 and the search continues with gt priority.
